// File: rtl/beep_decode.sv
`timescale 1ns/1ps
// beep_decode: measures half-periods of an asynchronous square-wave tone and
// decodes them into a low/middle octave note code through acquire/lock/timeout.
module beep_decode (
   input  logic       clk_5m,
   input  logic       rst_n,
   input  logic       beep_in,
   output logic [3:0] med,
   output logic [3:0] low,
   output logic       valid,
   output logic       note_chg
);

   localparam logic [1:0]  S_SILENT  = 2'd0;
   localparam logic [1:0]  S_ACQ     = 2'd1;
   localparam logic [1:0]  S_LOCKED  = 2'd2;
   localparam logic [1:0]  K_NOMATCH = 2'd0;
   localparam logic [1:0]  K_REST    = 2'd1;
   localparam logic [1:0]  K_NOTE    = 2'd2;
   localparam logic [13:0] CNT_MAX   = 14'h3FFF;
   localparam logic [13:0] REST_LIM  = 14'd16;
   localparam logic [14:0] TOL       = 15'd64;

   function automatic logic [13:0] f_nom_low(input logic [2:0] n);
      case (n)
         3'd1:    f_nom_low = 14'd9559;
         3'd2:    f_nom_low = 14'd8514;
         3'd3:    f_nom_low = 14'd7587;
         3'd4:    f_nom_low = 14'd7161;
         3'd5:    f_nom_low = 14'd6380;
         3'd6:    f_nom_low = 14'd5684;
         3'd7:    f_nom_low = 14'd5064;
         default: f_nom_low = 14'd0;
      endcase
   endfunction

   function automatic logic [13:0] f_nom_med(input logic [2:0] n);
      case (n)
         3'd1:    f_nom_med = 14'd4779;
         3'd2:    f_nom_med = 14'd4259;
         3'd3:    f_nom_med = 14'd3794;
         3'd4:    f_nom_med = 14'd3581;
         3'd5:    f_nom_med = 14'd3191;
         3'd6:    f_nom_med = 14'd2843;
         3'd7:    f_nom_med = 14'd2533;
         default: f_nom_med = 14'd0;
      endcase
   endfunction

   function automatic logic f_near(input logic [13:0] h, input logic [13:0] nom);
      f_near = (({1'b0, h} + TOL) >= {1'b0, nom}) && ({1'b0, h} <= ({1'b0, nom} + TOL));
   endfunction

   // Result is {kind, med, low}; nominal windows never overlap, so order is irrelevant.
   function automatic logic [9:0] f_classify(input logic [13:0] h);
      logic [9:0] res;
      logic [2:0] n;
      res = {K_NOMATCH, 8'h00};
      if (h < REST_LIM) begin
         res = {K_REST, 8'h00};
      end else begin
         for (int i = 1; i < 8; i++) begin
            n = i[2:0];
            if (f_near(h, f_nom_low(n))) begin
               res = {K_NOTE, 4'h0, 1'b0, n};
            end else if (f_near(h, f_nom_med(n))) begin
               res = {K_NOTE, 1'b0, n, 4'h0};
            end else begin
               res = res;
            end
         end
      end
      f_classify = res;
   endfunction

   logic        r_sync1, r_sync2, r_dly;
   logic [13:0] r_cnt;
   logic [1:0]  r_state;
   logic [7:0]  r_cand;
   logic        r_cand_v;
   logic [3:0]  r_med, r_low;
   logic        r_valid, r_note_chg;

   logic        w_edge, w_timeout, w_hit, w_chg;
   logic [9:0]  w_cls;
   logic [1:0]  w_kind, w_state_n;
   logic [7:0]  w_code, w_cand_n;
   logic        w_cand_v_n, w_valid_n;
   logic [3:0]  w_med_n, w_low_n;

   assign w_edge    = r_sync2 ^ r_dly;
   assign w_timeout = (r_cnt == CNT_MAX);

   // Two-flop synchronizer plus delay flop for both-edge detection.
   always_ff @(posedge clk_5m or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_dly   <= 1'b0;
      end else begin
         r_sync1 <= beep_in;
         r_sync2 <= r_sync1;
         r_dly   <= r_sync2;
      end
   end

   // Half-period counter: restarts at 1 on every edge, saturates at full scale.
   always_ff @(posedge clk_5m or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 14'd0;
      end else if (w_edge) begin
         r_cnt <= 14'd1;
      end else if (!w_timeout) begin
         r_cnt <= r_cnt + 14'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Next-state logic; timeout wins and a coincident edge then starts acquisition.
   always_comb begin
      w_cls      = f_classify(r_cnt);
      w_kind     = w_cls[9:8];
      w_code     = w_cls[7:0];
      w_hit      = (w_kind != K_NOMATCH);
      w_state_n  = r_state;
      w_cand_n   = r_cand;
      w_cand_v_n = r_cand_v;
      w_med_n    = r_med;
      w_low_n    = r_low;
      w_valid_n  = r_valid;
      if (w_timeout) begin
         w_state_n  = w_edge ? S_ACQ : S_SILENT;
         w_cand_n   = 8'h00;
         w_cand_v_n = 1'b0;
         w_med_n    = 4'h0;
         w_low_n    = 4'h0;
         w_valid_n  = 1'b0;
      end else if (w_edge) begin
         case (r_state)
            S_SILENT: begin
               w_state_n  = S_ACQ;
               w_cand_n   = 8'h00;
               w_cand_v_n = 1'b0;
            end
            S_ACQ: begin
               if (w_hit && r_cand_v && (w_code == r_cand)) begin
                  w_state_n          = S_LOCKED;
                  {w_med_n, w_low_n} = w_code;
                  w_valid_n          = (w_kind == K_NOTE);
               end else begin
                  w_cand_n   = w_hit ? w_code : 8'h00;
                  w_cand_v_n = w_hit;
               end
            end
            S_LOCKED: begin
               if (w_hit && (w_code == {r_med, r_low})) begin
                  w_state_n = S_LOCKED;
               end else begin
                  w_state_n  = S_ACQ;
                  w_cand_n   = w_hit ? w_code : 8'h00;
                  w_cand_v_n = w_hit;
               end
            end
            default: begin
               w_state_n  = S_SILENT;
               w_cand_n   = 8'h00;
               w_cand_v_n = 1'b0;
            end
         endcase
      end else begin
         w_state_n = r_state;
      end
      w_chg = ({w_med_n, w_low_n, w_valid_n} != {r_med, r_low, r_valid});
   end

   // FSM, candidate and registered outputs.
   always_ff @(posedge clk_5m or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_SILENT;
         r_cand     <= 8'h00;
         r_cand_v   <= 1'b0;
         r_med      <= 4'h0;
         r_low      <= 4'h0;
         r_valid    <= 1'b0;
         r_note_chg <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_cand     <= w_cand_n;
         r_cand_v   <= w_cand_v_n;
         r_med      <= w_med_n;
         r_low      <= w_low_n;
         r_valid    <= w_valid_n;
         r_note_chg <= w_chg;
      end
   end

   assign med      = r_med;
   assign low      = r_low;
   assign valid    = r_valid;
   assign note_chg = r_note_chg;

endmodule

// File: tb/tb_beep_decode.sv
`timescale 1ns/1ps
// Directed bench for beep_decode: tone lock, note change, glitch, rest,
// silence timeout, tolerance boundary and asynchronous reset mid-tone.
module tb_beep_decode;

   logic       clk_5m;
   logic       rst_n;
   logic       beep_in;
   logic [3:0] med, low;
   logic       valid, note_chg;

   int n_checks = 0;
   int n_errors = 0;
   int chg_cnt  = 0;
   int since    = 0;
   int base     = 0;

   beep_decode dut (
      .clk_5m   (clk_5m),
      .rst_n    (rst_n),
      .beep_in  (beep_in),
      .med      (med),
      .low      (low),
      .valid    (valid),
      .note_chg (note_chg)
   );

   initial clk_5m = 1'b0;
   always #100 clk_5m = ~clk_5m;

   // note_chg pulses are counted away from the active edge
   always @(negedge clk_5m) begin
      if (rst_n && note_chg) chg_cnt <= chg_cnt + 1;
   end

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_5m);
      #1;
      since += n;
   endtask

   task automatic tog();
      beep_in = ~beep_in;
      since   = 0;
   endtask

   // toggle so that the half-period ending now lasts exactly p cycles
   task automatic step(input int p);
      tick(p - since);
      tog();
   endtask

   task automatic chk_out(input string tag, input int m, input int l, input int v);
      chk_val({tag, "_med"}, 32'(med), 32'(m));
      chk_val({tag, "_low"}, 32'(low), 32'(l));
      chk_val({tag, "_valid"}, 32'(valid), 32'(v));
   endtask

   initial begin
      rst_n   = 1'b0;
      beep_in = 1'b0;
      repeat (3) @(posedge clk_5m);
      #1;
      chk_out("reset", 0, 0, 0);
      chk_val("reset_chg", 32'(note_chg), 32'd0);
      #50 rst_n = 1'b1;
      @(posedge clk_5m);
      #1;
      since = 0;

      // steady M1: locks on the third toggle, within 4 cycles
      base = chg_cnt;
      tog();
      step(4779);
      tick(4);
      chk_out("m1_cand", 0, 0, 0);
      step(4779);
      tick(4);
      chk_out("m1_lock", 1, 0, 1);
      chk_val("m1_chg", 32'(chg_cnt - base), 32'd1);

      // M2: first half only becomes the candidate
      step(4259);
      tick(4);
      chk_out("m2_cand", 1, 0, 1);
      chk_val("m1_hold_chg", 32'(chg_cnt - base), 32'd1);
      step(4259);
      tick(4);
      chk_out("m2_lock", 2, 0, 1);
      chk_val("m2_chg", 32'(chg_cnt - base), 32'd2);

      // asynchronous reset mid half-period
      tick(100);
      #50 rst_n = 1'b0;
      #10;
      chk_out("rst_async", 0, 0, 0);
      chk_val("rst_async_chg", 32'(note_chg), 32'd0);
      beep_in = 1'b0;
      repeat (4) @(posedge clk_5m);
      #50 rst_n = 1'b1;
      @(posedge clk_5m);
      #1;
      since = 0;
      base  = chg_cnt;
      tog();
      step(4259);
      tick(4);
      chk_out("relock_cand", 0, 0, 0);
      step(4259);
      tick(4);
      chk_out("relock_m2", 2, 0, 1);
      chk_val("relock_chg", 32'(chg_cnt - base), 32'd1);

      // L5 then switch to M6: change exactly after two M6 half-periods
      step(6380);
      step(6380);
      tick(4);
      chk_out("l5_lock", 0, 5, 1);
      base = chg_cnt;
      step(2843);
      tick(4);
      chk_out("m6_first", 0, 5, 1);
      step(2843);
      tick(4);
      chk_out("m6_lock", 6, 0, 1);
      chk_val("m6_chg", 32'(chg_cnt - base), 32'd1);

      // M3 with a stray 500-cycle half-period
      step(3794);
      step(3794);
      tick(4);
      chk_out("m3_lock", 3, 0, 1);
      base = chg_cnt;
      step(500);
      tick(4);
      chk_out("glitch", 3, 0, 1);
      chk_val("glitch_chg", 32'(chg_cnt - base), 32'd0);

      // rest: short half-periods lock to code 0 with valid low
      step(10);
      tick(4);
      chk_out("rest_cand", 3, 0, 1);
      step(2);
      step(2);
      step(2);
      tick(4);
      chk_out("rest_lock", 0, 0, 0);
      chk_val("rest_chg", 32'(chg_cnt - base), 32'd1);

      // static input: timeout to silence with unchanged outputs
      base = chg_cnt;
      tick(16400);
      chk_out("silent", 0, 0, 0);
      chk_val("silent_chg", 32'(chg_cnt - base), 32'd0);

      // L1 tolerance: 9623 (+64) locks, 9624 (+65) is no match
      tog();
      step(9623);
      tick(4);
      chk_out("l1_cand", 0, 0, 0);
      step(9623);
      tick(4);
      chk_out("l1_lock", 0, 1, 1);
      chk_val("l1_chg", 32'(chg_cnt - base), 32'd1);
      step(9624);
      tick(4);
      chk_out("l1_nomatch", 0, 1, 1);
      chk_val("l1_nomatch_chg", 32'(chg_cnt - base), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/beep_decode.md
BEEP_DECODE -- requirements
Module: beep_decode

Interface
REQ-001 clk_5m  input  1  5 MHz system clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk_5m.
REQ-003 beep_in  input  1  square-wave tone from the audio path; asynchronous to clk_5m.
REQ-004 med  output  4  decoded middle-octave note 1..7; 0 when the note is not middle-octave.
REQ-005 low  output  4  decoded low-octave note 1..7; 0 when the note is not low-octave.
REQ-006 valid  output  1  high while {med,low} holds a locked tone; low during rest or silence.
REQ-007 note_chg  output  1  one-cycle pulse whenever {med,low,valid} changes value.

Function
REQ-008 Sync: beep_in SHALL pass through a 2-flop synchronizer. An edge SHALL be detected when the synchronized value differs from a third delay flop, covering both rising and falling edges.
REQ-009 Half-period counter: 14-bit cnt SHALL load 1 on every detected edge and otherwise increment. It SHALL saturate at 16383.
REQ-010 Capture: on a detected edge, H = cnt value before reload. The first edge after reset or after silence SHALL start measurement only; no H is captured for that edge.
REQ-011 Match: H SHALL be classified against a nominal table with tolerance |H-nominal| <= 64.
- low: L1=9559, L2=8514, L3=7587, L4=7161, L5=6380, L6=5684, L7=5064.
- med: M1=4779, M2=4259, M3=3794, M4=3581, M5=3191, M6=2843, M7=2533.
- Code for Ln = {0000, n}; code for Mn = {n, 0000}.
REQ-012 If H < 16, H SHALL classify as REST, code 0000_0000.
REQ-013 Any other H SHALL classify as NOMATCH.
REQ-014 FSM states: SILENT, ACQ, LOCKED. ACQ holds a candidate code.
REQ-015 SILENT: a detected edge SHALL move to ACQ with no candidate.
REQ-016 ACQ:
- A classified H (REST or note) equal to the candidate SHALL move to LOCKED and update the outputs.
- Otherwise the classification SHALL become the new candidate.
- NOMATCH SHALL clear the candidate.
REQ-017 LOCKED:
- H classifying to the current code SHALL keep LOCKED with no output change.
- Any other classification SHALL move to ACQ with that classification as candidate (NOMATCH clears it); outputs hold.
REQ-018 Timeout: when cnt reaches 16383 in any state, the FSM SHALL go to SILENT and outputs SHALL become med=0, low=0, valid=0. If this changes the outputs, note_chg SHALL pulse.
REQ-019 Output update: in LOCKED, valid=1 for a note code and valid=0 for REST. Outputs SHALL be registered and change in the cycle after the capturing edge. note_chg SHALL be asserted in that same cycle.
REQ-020 Latency: the first valid note SHALL appear no later than 3 half-periods plus 4 cycles after the first beep_in toggle.
REQ-021 Simultaneous events: an edge detected in the same cycle cnt reaches 16383 SHALL be treated as an edge in SILENT (timeout first, then the edge enters ACQ).

Reset
REQ-022 While rst_n=0: state=SILENT, cnt=0, synchronizer and delay flops=0, candidate cleared, med=0, low=0, valid=0, note_chg=0.
REQ-023 Reset asserted mid-measurement SHALL discard the partial count. After release the block SHALL reacquire from SILENT.

Verification
REQ-024 Steady tone: beep_in toggles every 4779 cycles -> after 3 toggles, med=1, low=0, valid=1, one note_chg pulse; no further pulses while the tone holds.
REQ-025 Tolerance edge: half-periods 9623 then 9624 -> first locks L1 (low=1); second goes NOMATCH and enters ACQ while outputs hold low=1.
REQ-026 Note change: L5 (6380) steady, then switch to M6 (2843) -> outputs change to med=6, low=0 exactly 2 M6 half-periods after the switch, with a single note_chg pulse.
REQ-027 Rest/silence: toggle every 2 cycles -> valid=0, code 0. Then hold beep_in static -> after 16383 cycles state=SILENT, no extra note_chg pulse because the outputs are unchanged.
REQ-028 Glitch: one stray half-period of 500 inside an M3 (3794) tone -> outputs stay med=3, valid=1 throughout.
REQ-029 Reset mid-tone: assert rst_n=0 while locked on M2 -> all outputs 0 immediately (asynchronous). After release, relock to med=2 within 3 half-periods.
